// File: rtl/instr_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the program loader.
// The loader itself connects through the master modport.
interface instr_loader_if;
    logic        start_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        byte_ready_out;
    logic        instrWrite_out;
    logic [31:0] instr_address_out;
    logic [31:0] instr_out;
    logic        cpu_reset_out;
    logic        done_out;
    logic        error_out;

    modport master (
        input  start_in, byte_in, byte_valid_in,
        output byte_ready_out, instrWrite_out, instr_address_out, instr_out,
               cpu_reset_out, done_out, error_out
    );

    modport slave (
        output start_in, byte_in, byte_valid_in,
        input  byte_ready_out, instrWrite_out, instr_address_out, instr_out,
               cpu_reset_out, done_out, error_out
    );
endinterface

// File: rtl/instr_loader.sv
// Loads a length-prefixed big-endian program from a byte stream into instruction
// memory while holding the processor in reset; releases it once the load completes.
module instr_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input logic            clock_in,
    input logic            reset_in,
    instr_loader_if.master bus
);
    typedef enum logic [2:0] {IDLE, HEADER, LOAD, WRITE, DONE, ERROR} state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [7:0]  hdr_hi;
    logic [23:0] partial;
    logic [15:0] word_count;
    logic [15:0] index;

    logic        xfer;
    logic [15:0] hdr_n;
    logic [15:0] index_nxt;

    assign xfer      = bus.byte_valid_in && bus.byte_ready_out;
    assign hdr_n     = {hdr_hi, bus.byte_in};
    assign index_nxt = index + 16'd1;

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state                 <= IDLE;
            byte_cnt              <= 2'd0;
            hdr_hi                <= 8'd0;
            partial               <= 24'd0;
            word_count            <= 16'd0;
            index                 <= 16'd0;
            bus.byte_ready_out    <= 1'b0;
            bus.instrWrite_out    <= 1'b0;
            bus.instr_address_out <= 32'd0;
            bus.instr_out         <= 32'd0;
            bus.cpu_reset_out     <= 1'b0;
            bus.done_out          <= 1'b0;
            bus.error_out         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start_in) begin
                        state              <= HEADER;
                        byte_cnt           <= 2'd0;
                        index              <= 16'd0;
                        bus.byte_ready_out <= 1'b1;
                        bus.cpu_reset_out  <= 1'b0;
                        bus.done_out       <= 1'b0;
                        bus.error_out      <= 1'b0;
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        if (byte_cnt == 2'd0) begin
                            hdr_hi   <= bus.byte_in;
                            byte_cnt <= 2'd1;
                        end else begin
                            byte_cnt   <= 2'd0;
                            word_count <= hdr_n;
                            if (hdr_n == 16'd0) begin
                                state              <= DONE;
                                bus.byte_ready_out <= 1'b0;
                                bus.done_out       <= 1'b1;
                                bus.cpu_reset_out  <= 1'b1;
                            end else if (int'(hdr_n) > MAX_WORDS) begin
                                state              <= ERROR;
                                bus.byte_ready_out <= 1'b0;
                                bus.error_out      <= 1'b1;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    // The word is published only on its 4th byte so the memory
                    // never sees a partially assembled instruction.
                    if (xfer) begin
                        if (byte_cnt == 2'd3) begin
                            state                 <= WRITE;
                            byte_cnt              <= 2'd0;
                            bus.byte_ready_out    <= 1'b0;
                            bus.instrWrite_out    <= 1'b1;
                            bus.instr_out         <= {partial, bus.byte_in};
                            bus.instr_address_out <= BASE_ADDR + {14'd0, index, 2'b00};
                        end else begin
                            partial  <= {partial[15:0], bus.byte_in};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    bus.instrWrite_out <= 1'b0;
                    index              <= index_nxt;
                    if (index_nxt < word_count) begin
                        state              <= LOAD;
                        bus.byte_ready_out <= 1'b1;
                    end else begin
                        state             <= DONE;
                        bus.done_out      <= 1'b1;
                        bus.cpu_reset_out <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first instruction written.
REQ-002 Parameter MAX_WORDS, default 256: largest accepted program length in words.
REQ-003 clock_in  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_in  input  1  synchronous, active-low reset, sampled on the rising edge of clock_in.
REQ-005 start_in  input  1  one-cycle request to begin a program load.
REQ-006 byte_in  input  8  program byte stream data.
REQ-007 byte_valid_in  input  1  byte_in holds a valid byte.
REQ-008 byte_ready_out  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid_in and byte_ready_out are both 1.
REQ-009 instrWrite_out  output  1  one-cycle write strobe to the processor instruction memory.
REQ-010 instr_address_out  output  32  byte address of the instruction being written.
REQ-011 instr_out  output  32  assembled instruction word.
REQ-012 cpu_reset_out  output  1  active-low reset to the processor; 0 holds the processor in reset.
REQ-013 done_out  output  1  load completed successfully.
REQ-014 error_out  output  1  header rejected.

Function
REQ-015 The FSM SHALL have states IDLE, HEADER, LOAD, WRITE, DONE and ERROR.
REQ-016 IDLE: byte_ready_out 0; start_in=1 moves to HEADER, clears the byte counter, word index, done_out and error_out, and drives cpu_reset_out 0.
REQ-017 HEADER: byte_ready_out 1; it accepts 2 bytes forming a 16-bit word count N, first byte most significant.
REQ-018 On the 2nd header byte: N=0 goes to DONE; N>MAX_WORDS goes to ERROR; otherwise the FSM goes to LOAD.
REQ-019 LOAD: byte_ready_out 1; it accepts 4 bytes per word, first byte to instr_out[31:24] and last byte to [7:0] (big-endian).
REQ-020 The 4th byte of a word, accepted in cycle k, SHALL move the FSM to WRITE, so instrWrite_out=1 in cycle k+1 with instr_out equal to the complete word.
REQ-021 WRITE: byte_ready_out 0 and instrWrite_out 1 for exactly one cycle, with instr_address_out = BASE_ADDR + 4*index (modulo 2^32, wrap permitted).
REQ-022 After WRITE, index increments; the FSM returns to LOAD if index<N, else goes to DONE.
REQ-023 DONE: done_out 1, cpu_reset_out 1, byte_ready_out 0; these hold until start_in or reset.
REQ-024 ERROR: error_out 1, cpu_reset_out 0, byte_ready_out 0; no instrWrite_out is issued.
REQ-025 start_in in DONE or ERROR SHALL restart exactly as from IDLE (next state HEADER).
REQ-026 start_in in HEADER, LOAD or WRITE SHALL be ignored.
REQ-027 byte_valid_in=0 stalls HEADER/LOAD indefinitely with no state change and no timeout.
REQ-028 Bytes presented while byte_ready_out=0 SHALL NOT be consumed or counted.
REQ-029 instr_address_out and instr_out SHALL hold their last written values outside WRITE.
REQ-030 instrWrite_out SHALL never be 1 in consecutive cycles, because of the minimum of 4 accepted bytes between writes.

Reset
REQ-031 reset_in=0 at a rising edge SHALL force the following, regardless of state: state IDLE, byte_ready_out 0, instrWrite_out 0, instr_address_out 0, instr_out 0, cpu_reset_out 0, done_out 0, error_out 0, byte counter 0, index 0.
REQ-032 Reset mid-load SHALL discard any partially assembled word and issue no write for it.
REQ-033 Reset asserted in the same cycle as start_in or a byte transfer SHALL take priority.

Verification
REQ-034 Basic load: start, header 00 02, bytes 20 08 00 05 / 01 09 50 20 -> writes 32'h2008_0005 @0x0 and 32'h0109_5020 @0x4; then done_out=1, cpu_reset_out=1.
REQ-035 Zero length: start, header 00 00 -> DONE next cycle, no instrWrite_out pulse, cpu_reset_out=1.
REQ-036 Oversize: header 01 01 with MAX_WORDS=256 -> error_out=1, cpu_reset_out=0, byte_ready_out=0, no writes.
REQ-037 Stalls and latency: random byte_valid_in gaps across one word -> same word written, instrWrite_out exactly one cycle after the 4th accepted byte.
REQ-038 Reset mid-word: after 2 of 4 bytes, reset_in=0 for one cycle -> all outputs at reset values, no write; a subsequent full load succeeds from index 0.
REQ-039 Restart and wrap: BASE_ADDR=32'hFFFF_FFFC, N=2 -> addresses 0xFFFF_FFFC then 0x0000_0000; start_in in DONE reloads correctly.
